// File: rtl/ifetch_window.sv
// ============================================================================
// Module      : ifetch_window
// Description : Builds the 10-byte instruction window for a byte-addressed
//               fetch PC from 3-4 words of a synchronous word-wide memory,
//               with a one-entry tag that short-circuits repeated fetches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_window #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              flush,
    output logic [INST_W-1:0] inst_o,
    output logic              inst_valid,
    output logic              mem_rd,
    output logic [ADDR_W-3:0] mem_addr,
    input  logic [31:0]       mem_rdata
);

    localparam int C_WADDR_W   = ADDR_W - 2;
    localparam int C_BUF_W     = 128;
    localparam int C_WIN_BYTES = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [ADDR_W-1:0]      r_req_addr;
    logic [1:0]             r_off;
    logic [C_WADDR_W-1:0]   r_base;
    logic [2:0]             r_iss_cnt;
    logic [2:0]             r_rcv_cnt;
    logic                   r_rd_d;
    logic [C_BUF_W-1:0]     r_buf;
    logic                   r_tag_valid;
    logic [ADDR_W-1:0]      r_tag_addr;

    logic                   w_accept;
    logic                   w_hit;
    logic [2:0]             w_nwords;
    logic                   w_issue_done;
    logic                   w_last;
    logic [C_BUF_W-1:0]     w_buf_nxt;
    logic [C_BUF_W-1:0]     w_stream;
    logic [INST_W-1:0]      w_window;

    assign req_ready    = (r_state == IDLE);
    assign w_accept     = req_valid && req_ready && !flush && !rst;
    assign w_hit        = r_tag_valid && (req_addr == r_tag_addr);
    assign w_nwords     = (r_off == 2'd3) ? 3'd4 : 3'd3;
    assign w_issue_done = (r_iss_cnt == w_nwords);

    // r_rd_d marks the cycle in which mem_rdata carries a word we asked for.
    assign w_last       = r_rd_d && (r_rcv_cnt == (w_nwords - 3'd1));

    // Buffer byte i holds the i-th fetched byte once four words are in; with
    // only three words the stream sits one word higher and is realigned here.
    assign w_buf_nxt    = {mem_rdata, r_buf[C_BUF_W-1:32]};
    assign w_stream     = (r_off == 2'd3) ? w_buf_nxt : {32'h0, w_buf_nxt[C_BUF_W-1:32]};

    always_comb begin
        w_window = '0;
        for (int k = 0; k < C_WIN_BYTES; k++) begin
            w_window[INST_W-1-8*k -: 8] = w_stream[8*(int'(r_off)+k) +: 8];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept && !w_hit) w_state_nxt = ISSUE;
                ISSUE:   if (w_issue_done)       w_state_nxt = DRAIN;
                DRAIN:   if (w_last)             w_state_nxt = IDLE;
                default:                         w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_o      <= '0;
            inst_valid  <= 1'b0;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            r_req_addr  <= '0;
            r_off       <= 2'd0;
            r_base      <= '0;
            r_iss_cnt   <= 3'd0;
            r_rcv_cnt   <= 3'd0;
            r_rd_d      <= 1'b0;
            r_buf       <= '0;
            r_tag_valid <= 1'b0;
            r_tag_addr  <= '0;
        end else begin
            inst_valid <= 1'b0;
            if (flush) begin
                // Clearing r_rd_d drops the word still in flight from memory.
                mem_rd      <= 1'b0;
                r_rd_d      <= 1'b0;
                r_tag_valid <= 1'b0;
            end else begin
                r_rd_d <= mem_rd;
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            if (w_hit) begin
                                inst_valid <= 1'b1;
                            end else begin
                                r_tag_valid <= 1'b0;
                                r_req_addr  <= req_addr;
                                r_off       <= req_addr[1:0];
                                r_base      <= req_addr[ADDR_W-1:2];
                                mem_rd      <= 1'b1;
                                mem_addr    <= req_addr[ADDR_W-1:2];
                                r_iss_cnt   <= 3'd1;
                                r_rcv_cnt   <= 3'd0;
                            end
                        end
                    end
                    ISSUE: begin
                        if (w_issue_done) begin
                            mem_rd <= 1'b0;
                        end else begin
                            mem_rd    <= 1'b1;
                            mem_addr  <= r_base + C_WADDR_W'(r_iss_cnt);
                            r_iss_cnt <= r_iss_cnt + 3'd1;
                        end
                    end
                    default: ;
                endcase

                if (r_rd_d) begin
                    r_buf     <= w_buf_nxt;
                    r_rcv_cnt <= r_rcv_cnt + 3'd1;
                end

                if (w_last) begin
                    inst_o      <= w_window;
                    inst_valid  <= 1'b1;
                    r_tag_addr  <= r_req_addr;
                    r_tag_valid <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ifetch_window.sv
// ============================================================================
// Module      : tb_ifetch_window
// Description : Directed self-checking bench for ifetch_window; memory byte at
//               address a holds a[7:0].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch_window;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        flush;
    logic [79:0] inst_o;
    logic        inst_valid;
    logic        mem_rd;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    ifetch_window #(
        .ADDR_W(32),
        .INST_W(80)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .flush     (flush),
        .inst_o    (inst_o),
        .inst_valid(inst_valid),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word w holds bytes 4w..4w+3 (low 8 bits of each address), little-endian.
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata <= {mem_addr[5:0], 2'd3, mem_addr[5:0], 2'd2,
                          mem_addr[5:0], 2'd1, mem_addr[5:0], 2'd0};
        end else begin
            mem_rdata <= 32'hDEADBEEF;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        flush     = 1'b0;
        step();
        step();
        chk("rst_inst",  128'(inst_o),     128'h0);
        chk("rst_valid", 128'(inst_valid), 128'd0);
        chk("rst_rd",    128'(mem_rd),     128'd0);
        chk("rst_addr",  128'(mem_addr),   128'd0);
        rst = 1'b0;
        step();
        chk("rst_ready", 128'(req_ready),  128'd1);

        // Aligned miss at 0x0: three reads, window at T+5
        req_valid = 1'b1; req_addr = 32'h0000_0000;
        step(); req_valid = 1'b0;                           // T+1
        chk("a0_rd1",    128'(mem_rd),   128'd1);
        chk("a0_addr1",  128'(mem_addr), 128'd0);
        chk("a0_ready1", 128'(req_ready), 128'd0);
        step();                                             // T+2
        chk("a0_addr2",  128'(mem_addr), 128'd1);
        step();                                             // T+3
        chk("a0_addr3",  128'(mem_addr), 128'd2);
        step();                                             // T+4
        chk("a0_rd4",    128'(mem_rd),     128'd0);
        chk("a0_valid4", 128'(inst_valid), 128'd0);
        step();                                             // T+5
        chk("a0_valid5", 128'(inst_valid), 128'd1);
        chk("a0_inst",   128'(inst_o),     128'h0001_0203_0405_0607_0809);
        chk("a0_ready5", 128'(req_ready),  128'd1);
        step();
        chk("a0_valid6", 128'(inst_valid), 128'd0);

        // Offset-3 miss: four reads, window at T+6
        req_valid = 1'b1; req_addr = 32'h0000_0003;
        step(); req_valid = 1'b0;                           // T+1
        chk("a3_addr1",  128'(mem_addr), 128'd0);
        step(); step(); step();                             // T+4
        chk("a3_rd4",    128'(mem_rd),   128'd1);
        chk("a3_addr4",  128'(mem_addr), 128'd3);
        step();                                             // T+5
        chk("a3_rd5",    128'(mem_rd),     128'd0);
        chk("a3_valid5", 128'(inst_valid), 128'd0);
        step();                                             // T+6
        chk("a3_valid6", 128'(inst_valid), 128'd1);
        chk("a3_inst",   128'(inst_o),     128'h0304_0506_0708_090A_0B0C);

        // Hit accepted in the inst_valid cycle, then a back-to-back hit
        req_valid = 1'b1; req_addr = 32'h0000_0003;
        step();
        chk("hit_valid1", 128'(inst_valid), 128'd1);
        chk("hit_rd1",    128'(mem_rd),     128'd0);
        chk("hit_ready1", 128'(req_ready),  128'd1);
        chk("hit_inst1",  128'(inst_o),     128'h0304_0506_0708_090A_0B0C);
        step(); req_valid = 1'b0;
        chk("hit_valid2", 128'(inst_valid), 128'd1);
        chk("hit_rd2",    128'(mem_rd),     128'd0);
        step();
        chk("hit_valid3", 128'(inst_valid), 128'd0);

        // Miss at 0x10 flushed at T+3, then re-requested at T+4
        req_valid = 1'b1; req_addr = 32'h0000_0010;
        step(); req_valid = 1'b0;                           // T+1
        step(); step();                                     // T+3
        chk("fl_addr3", 128'(mem_addr), 128'd6);
        flush = 1'b1;
        step(); flush = 1'b0;                               // T+4
        chk("fl_ready4", 128'(req_ready),  128'd1);
        chk("fl_rd4",    128'(mem_rd),     128'd0);
        chk("fl_valid4", 128'(inst_valid), 128'd0);
        chk("fl_inst4",  128'(inst_o),     128'h0304_0506_0708_090A_0B0C);
        req_valid = 1'b1; req_addr = 32'h0000_0010;
        step(); req_valid = 1'b0;                           // T'+1
        chk("rf_rd1",    128'(mem_rd),     128'd1);
        chk("rf_addr1",  128'(mem_addr),   128'd4);
        chk("rf_valid1", 128'(inst_valid), 128'd0);
        step(); step(); step();                             // T'+4
        chk("rf_valid4", 128'(inst_valid), 128'd0);
        step();                                             // T'+5
        chk("rf_valid5", 128'(inst_valid), 128'd1);
        chk("rf_inst",   128'(inst_o),     128'h1011_1213_1415_1617_1819);

        // Word-address wrap from 0xFFFFFFFE
        req_valid = 1'b1; req_addr = 32'hFFFF_FFFE;
        step(); req_valid = 1'b0;                           // T+1
        chk("wr_addr1", 128'(mem_addr), 128'h3FFF_FFFF);
        step();
        chk("wr_addr2", 128'(mem_addr), 128'h0);
        step();
        chk("wr_addr3", 128'(mem_addr), 128'h1);
        step(); step();                                     // T+5
        chk("wr_valid5", 128'(inst_valid), 128'd1);
        chk("wr_inst",   128'(inst_o),     128'hFEFF_0001_0203_0405_0607);

        // Reset asserted at T+2 of a miss
        req_valid = 1'b1; req_addr = 32'h0000_0020;
        step(); req_valid = 1'b0;                           // T+1
        step();                                             // T+2
        rst = 1'b1;
        step(); rst = 1'b0;                                 // T+3
        chk("mr_inst",  128'(inst_o),     128'h0);
        chk("mr_valid", 128'(inst_valid), 128'd0);
        chk("mr_rd",    128'(mem_rd),     128'd0);
        chk("mr_addr",  128'(mem_addr),   128'd0);
        chk("mr_ready", 128'(req_ready),  128'd1);
        step();
        chk("mr_valid4", 128'(inst_valid), 128'd0);
        step();
        chk("mr_valid5", 128'(inst_valid), 128'd0);

        // Cold request after reset
        req_valid = 1'b1; req_addr = 32'h0000_0020;
        step(); req_valid = 1'b0;                           // T+1
        chk("cold_rd1",   128'(mem_rd),   128'd1);
        chk("cold_addr1", 128'(mem_addr), 128'd8);
        step(); step(); step(); step();                     // T+5
        chk("cold_valid5", 128'(inst_valid), 128'd1);
        chk("cold_inst",   128'(inst_o),     128'h2021_2223_2425_2627_2829);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
